// File: rtl/round_sequencer.sv
// -----------------------------------------------------------------------------
// round_sequencer
//
// Phase sequencer for one bomb-dismantlement round. It waits for a start
// button edge, latches a 5-bit pseudo-random code, runs the timed
// code-display phase, then the countdown/entry phase, and resolves the round
// to WIN or LOSE. After the result has been held for END_SEC seconds it
// returns to IDLE on its own. It also drives the enables of the downstream
// display and entry blocks, and gives them a one-cycle reset pulse at every
// round start.
//
// Parameters:
//   CLK_HZ     clk cycles per 1 s tick (>= 2)
//   SHOW_SEC   seconds the code is displayed
//   INPUT_SEC  seconds allowed for code entry (1..31)
//   END_SEC    seconds the WIN/LOSE result is held (>= 1)
//
// Ports:
//   clk        system clock
//   rst_p      asynchronous, active-high reset
//   sw_en      master enable; low forces IDLE on the next edge
//   btn_start  debounced start button level; rising edge detected here
//   code_ok    one-cycle pulse: correct code entered
//   code_bad   one-cycle pulse: wrong code entered
//   code       round code, stable from SHOW entry until the next round start
//   sub_rst    one-cycle reset pulse to display/entry blocks (first SHOW cycle)
//   bomb_en    bomb matrix display enable (SHOW, INPUT)
//   show_en    code display enable (SHOW)
//   input_en   code-entry checker enable (INPUT)
//   secs_left  countdown value for the 7-segment display
//   success    high in WIN
//   fail       high in LOSE
//
// Optional feature (macro DIFFICULTY_RAMP_EN):
//   When it is defined, a win-streak counter shortens the entry window by
//   2 s per consecutive win, down to a 4 s floor. When it is undefined, the
//   entry window is always INPUT_SEC.
// -----------------------------------------------------------------------------
module round_sequencer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SHOW_SEC  = 5,
  parameter int INPUT_SEC = 20,
  parameter int END_SEC   = 3
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       sw_en,
  input  logic       btn_start,
  input  logic       code_ok,
  input  logic       code_bad,
  output logic [4:0] code,
  output logic       sub_rst,
  output logic       bomb_en,
  output logic       show_en,
  output logic       input_en,
  output logic [4:0] secs_left,
  output logic       success,
  output logic       fail
);

  localparam int               TICK_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLK_HZ - 1);
  localparam int               END_W      = (END_SEC > 1) ? $clog2(END_SEC) : 1;
  localparam logic [END_W-1:0]  END_MAX   = END_W'(END_SEC - 1);
  localparam logic [4:0]        SHOW_LOAD  = 5'(SHOW_SEC);
  localparam logic [4:0]        INPUT_LOAD = 5'(INPUT_SEC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_e;

  state_e            state_q,    state_d;
  logic [4:0]        lfsr_q,     lfsr_d;
  logic              btn_q,      btn_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [END_W-1:0]  end_cnt_q,  end_cnt_d;
  logic [4:0]        code_q,     code_d;
  logic [4:0]        secs_q,     secs_d;
  logic              sub_rst_q,  sub_rst_d;
  logic              bomb_en_q,  bomb_en_d;
  logic              show_en_q,  show_en_d;
  logic              input_en_q, input_en_d;
  logic              success_q,  success_d;
  logic              fail_q,     fail_d;

  logic       tick;
  logic       start_edge;
  logic [4:0] input_load;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign start_edge = btn_start & ~btn_q;

  // Fibonacci form of x^5 + x^3 + 1. The polynomial is primitive, so from any
  // non-zero seed it walks all 31 non-zero states and never locks up at zero.
  assign lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  assign btn_d  = btn_start;

`ifdef DIFFICULTY_RAMP_EN
  logic [4:0] streak_q, streak_d;
  logic [6:0] ramp_cut;

  // The entry window shrinks by 2 s per consecutive win but never drops
  // below 4 s. The comparison is done before the subtraction so it cannot wrap.
  always_comb begin
    ramp_cut = {1'b0, streak_q, 1'b0};
    if (7'(INPUT_SEC) >= ramp_cut + 7'd4) begin
      input_load = 5'(7'(INPUT_SEC) - ramp_cut);
    end else begin
      input_load = 5'd4;
    end
  end

  // The streak is updated from the resolved transition, so it follows the
  // same code_ok > code_bad > timeout priority as the FSM.
  always_comb begin
    streak_d = streak_q;
    if (!sw_en) begin
      streak_d = '0;
    end else if (state_q == S_INPUT && state_d == S_WIN) begin
      streak_d = (streak_q == 5'd15) ? streak_q : streak_q + 5'd1;
    end else if (state_q == S_INPUT && state_d == S_LOSE) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  assign input_load = INPUT_LOAD;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so paths
    // that do not assign it hold or clear it instead of inferring a latch.
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end_cnt_d  = end_cnt_q;
    code_d     = code_q;
    secs_d     = secs_q;
    sub_rst_d  = 1'b0;

    if (!sw_en) begin
      // The master switch overrides every state. code is kept on purpose.
      state_d = S_IDLE;
      secs_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          secs_d = '0;
          if (start_edge) begin
            state_d   = S_SHOW;
            code_d    = lfsr_q;
            secs_d    = SHOW_LOAD;
            sub_rst_d = 1'b1;
          end
        end

        S_SHOW: begin
          if (tick) begin
            if (secs_q == 5'd1) begin
              state_d = S_INPUT;
              secs_d  = input_load;
            end else begin
              secs_d = secs_q - 5'd1;
            end
          end
        end

        S_INPUT: begin
          // A result entered in the same cycle as the final tick beats the
          // timeout. secs_left then freezes at its current value.
          if (code_ok) begin
            state_d = S_WIN;
          end else if (code_bad) begin
            state_d = S_LOSE;
          end else if (tick) begin
            if (secs_q == 5'd1) begin
              state_d = S_LOSE;
              secs_d  = '0;
            end else begin
              secs_d = secs_q - 5'd1;
            end
          end
        end

        S_WIN, S_LOSE: begin
          if (tick) begin
            end_cnt_d = end_cnt_q + END_W'(1);
            if (end_cnt_q == END_MAX) begin
              state_d = S_IDLE;
              secs_d  = '0;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          secs_d  = '0;
        end
      endcase
    end

    // Each phase times itself from its own first cycle.
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      end_cnt_d  = '0;
    end

    // The outputs decode the next state and are then registered, so they
    // change on the same edge as the state.
    bomb_en_d  = (state_d == S_SHOW) || (state_d == S_INPUT);
    show_en_d  = (state_d == S_SHOW);
    input_en_d = (state_d == S_INPUT);
    success_d  = (state_d == S_WIN);
    fail_d     = (state_d == S_LOSE);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 5'b00001;
      btn_q      <= 1'b0;
      tick_cnt_q <= '0;
      end_cnt_q  <= '0;
      code_q     <= '0;
      secs_q     <= '0;
      sub_rst_q  <= 1'b0;
      bomb_en_q  <= 1'b0;
      show_en_q  <= 1'b0;
      input_en_q <= 1'b0;
      success_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines does not matter.
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      btn_q      <= btn_d;
      tick_cnt_q <= tick_cnt_d;
      end_cnt_q  <= end_cnt_d;
      code_q     <= code_d;
      secs_q     <= secs_d;
      sub_rst_q  <= sub_rst_d;
      bomb_en_q  <= bomb_en_d;
      show_en_q  <= show_en_d;
      input_en_q <= input_en_d;
      success_q  <= success_d;
      fail_q     <= fail_d;
    end
  end

  assign code      = code_q;
  assign sub_rst   = sub_rst_q;
  assign bomb_en   = bomb_en_q;
  assign show_en   = show_en_q;
  assign input_en  = input_en_q;
  assign secs_left = secs_q;
  assign success   = success_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_round_sequencer
//
// Self-checking bench for round_sequencer with CLK_HZ=4, SHOW_SEC=5,
// INPUT_SEC=20 and END_SEC=3. A reference model tracks the round phase and
// the number of cycles spent in it, and derives the countdown by division.
// Scenario tasks check the directed expectations. A randomized phase then
// compares every output against the model on every cycle. Inputs change on
// the falling edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_round_sequencer;

  localparam int CLK_HZ    = 4;
  localparam int SHOW_SEC  = 5;
  localparam int INPUT_SEC = 20;
  localparam int END_SEC   = 3;

  localparam int P_IDLE  = 0;
  localparam int P_SHOW  = 1;
  localparam int P_INPUT = 2;
  localparam int P_WIN   = 3;
  localparam int P_LOSE  = 4;

  logic       clk = 1'b0;
  logic       rst_p;
  logic       sw_en;
  logic       btn_start;
  logic       code_ok;
  logic       code_bad;
  logic [4:0] code;
  logic       sub_rst;
  logic       bomb_en;
  logic       show_en;
  logic       input_en;
  logic [4:0] secs_left;
  logic       success;
  logic       fail;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_phase;
  int m_cyc;
  int m_secs;
  int m_code;
  int m_lfsr;
  int m_load;
  int m_streak;
  bit m_btn_prev;
  bit m_sub_rst;

  round_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .SHOW_SEC (SHOW_SEC),
    .INPUT_SEC(INPUT_SEC),
    .END_SEC  (END_SEC)
  ) dut (
    .clk      (clk),
    .rst_p    (rst_p),
    .sw_en    (sw_en),
    .btn_start(btn_start),
    .code_ok  (code_ok),
    .code_bad (code_bad),
    .code     (code),
    .sub_rst  (sub_rst),
    .bomb_en  (bomb_en),
    .show_en  (show_en),
    .input_en (input_en),
    .secs_left(secs_left),
    .success  (success),
    .fail     (fail)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model --
  function automatic int lfsr_next(input int v);
    return ((v << 1) & 31) | (((v >> 4) ^ (v >> 2)) & 1);
  endfunction

  function automatic int entry_window(input int streak);
`ifdef DIFFICULTY_RAMP_EN
    int t;
    t = INPUT_SEC - 2 * streak;
    return (t < 4) ? 4 : t;
`else
    return INPUT_SEC + 0 * streak;
`endif
  endfunction

  task automatic model_reset();
    m_phase    = P_IDLE;
    m_cyc      = 0;
    m_secs     = 0;
    m_code     = 0;
    m_lfsr     = 1;
    m_load     = 0;
    m_streak   = 0;
    m_btn_prev = 1'b0;
    m_sub_rst  = 1'b0;
  endtask

  task automatic model_step();
    int old_lfsr;
    old_lfsr  = m_lfsr;
    m_lfsr    = lfsr_next(m_lfsr);
    m_sub_rst = 1'b0;
    if (!sw_en) begin
      m_phase  = P_IDLE;
      m_cyc    = 0;
      m_secs   = 0;
      m_streak = 0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (btn_start && !m_btn_prev) begin
            m_phase   = P_SHOW;
            m_cyc     = 0;
            m_code    = old_lfsr;
            m_secs    = SHOW_SEC;
            m_sub_rst = 1'b1;
          end
        end
        P_SHOW: begin
          m_cyc++;
          if (m_cyc == SHOW_SEC * CLK_HZ) begin
            m_phase = P_INPUT;
            m_cyc   = 0;
            m_load  = entry_window(m_streak);
            m_secs  = m_load;
          end else begin
            m_secs = SHOW_SEC - m_cyc / CLK_HZ;
          end
        end
        P_INPUT: begin
          if (code_ok) begin
            m_phase  = P_WIN;
            m_cyc    = 0;
            m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
          end else if (code_bad) begin
            m_phase  = P_LOSE;
            m_cyc    = 0;
            m_streak = 0;
          end else begin
            m_cyc++;
            if (m_cyc == m_load * CLK_HZ) begin
              m_phase  = P_LOSE;
              m_cyc    = 0;
              m_secs   = 0;
              m_streak = 0;
            end else begin
              m_secs = m_load - m_cyc / CLK_HZ;
            end
          end
        end
        default: begin
          m_cyc++;
          if (m_cyc == END_SEC * CLK_HZ) begin
            m_phase = P_IDLE;
            m_cyc   = 0;
            m_secs  = 0;
          end
        end
      endcase
    end
    m_btn_prev = btn_start;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [4:0] c;
    logic [4:0] s;
    c = m_code[4:0];
    s = m_secs[4:0];
    return {c, m_sub_rst,
            (m_phase == P_SHOW) || (m_phase == P_INPUT),
            (m_phase == P_SHOW), (m_phase == P_INPUT),
            s, (m_phase == P_WIN), (m_phase == P_LOSE)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {code, sub_rst, bomb_en, show_en, input_en, secs_left, success, fail};
  endfunction

  // Advance one clock: the DUT and the model see the same inputs, and the
  // outputs are then available on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst_p) model_reset();
    else       model_step();
    @(negedge clk);
  endtask

  task automatic launch();
    btn_start = 1'b0;
    cyc();
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
  endtask

  // Clears any win streak so the entry window starts at INPUT_SEC.
  task automatic start_round();
    sw_en = 1'b0;
    cyc();
    sw_en = 1'b1;
    launch();
  endtask

  // ---------------------------------------------------------------- tests --
  task automatic test_reset();
    rst_p = 1'b1; sw_en = 1'b0; btn_start = 1'b0; code_ok = 1'b0; code_bad = 1'b0;
    model_reset();
    repeat (2) cyc();
    checks++; if (dut_vec() !== 16'h0000) begin errors++; $display("FAIL reset_outputs: got %h want 0000", dut_vec()); end
    rst_p = 1'b0;
    cyc();
    checks++; if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_start();
    sw_en = 1'b1;
    cyc();
    checks++; if (show_en !== 1'b0) begin errors++; $display("FAIL start_no_edge: show_en got %b want 0", show_en); end
    btn_start = 1'b1;
    cyc();
    checks++; if (sub_rst !== 1'b1) begin errors++; $display("FAIL start_sub_rst: got %b want 1", sub_rst); end
    checks++; if ({bomb_en, show_en, input_en} !== 3'b110) begin errors++; $display("FAIL start_enables: got %b want 110", {bomb_en, show_en, input_en}); end
    checks++; if (secs_left !== 5'd5) begin errors++; $display("FAIL start_secs: got %0d want 5", secs_left); end
    checks++; if (code !== 5'(m_code)) begin errors++; $display("FAIL start_code: got %0d want %0d", code, m_code); end
    btn_start = 1'b0;
    cyc();
    checks++; if (sub_rst !== 1'b0) begin errors++; $display("FAIL start_sub_rst_once: got %b want 0", sub_rst); end
    repeat (19) cyc();
    checks++; if ({bomb_en, show_en, input_en} !== 3'b101) begin errors++; $display("FAIL start_input_enables: got %b want 101", {bomb_en, show_en, input_en}); end
    checks++; if (secs_left !== 5'd20) begin errors++; $display("FAIL start_input_secs: got %0d want 20", secs_left); end
  endtask

  task automatic test_win();
    repeat (52) cyc();
    checks++; if (secs_left !== 5'd7) begin errors++; $display("FAIL win_pre_secs: got %0d want 7", secs_left); end
    code_ok = 1'b1;
    cyc();
    code_ok = 1'b0;
    checks++; if ({success, fail, input_en, bomb_en} !== 4'b1000) begin errors++; $display("FAIL win_flags: got %b want 1000", {success, fail, input_en, bomb_en}); end
    checks++; if (secs_left !== 5'd7) begin errors++; $display("FAIL win_secs_frozen: got %0d want 7", secs_left); end
    repeat (11) cyc();
    checks++; if (success !== 1'b1 || secs_left !== 5'd7) begin errors++; $display("FAIL win_hold: got success=%b secs=%0d want 1/7", success, secs_left); end
    cyc();
    checks++; if ({success, bomb_en, show_en, input_en} !== 4'b0000 || secs_left !== 5'd0) begin errors++; $display("FAIL win_to_idle: got %b secs=%0d want 0000 secs=0", {success, bomb_en, show_en, input_en}, secs_left); end
  endtask

  task automatic test_timeout();
    start_round();
    repeat (20) cyc();
    checks++; if (input_en !== 1'b1) begin errors++; $display("FAIL timeout_entry: input_en got %b want 1", input_en); end
    repeat (79) cyc();
    checks++; if (fail !== 1'b0 || input_en !== 1'b1 || secs_left !== 5'd1) begin errors++; $display("FAIL timeout_last_cycle: got fail=%b en=%b secs=%0d want 0/1/1", fail, input_en, secs_left); end
    cyc();
    checks++; if (fail !== 1'b1 || input_en !== 1'b0 || secs_left !== 5'd0) begin errors++; $display("FAIL timeout_lose: got fail=%b en=%b secs=%0d want 1/0/0", fail, input_en, secs_left); end
    repeat (12) cyc();
    checks++; if (fail !== 1'b0) begin errors++; $display("FAIL timeout_to_idle: fail got %b want 0", fail); end
  endtask

  task automatic test_simultaneous();
    start_round();
    repeat (30) cyc();
    code_ok = 1'b1; code_bad = 1'b1;
    cyc();
    code_ok = 1'b0; code_bad = 1'b0;
    checks++; if ({success, fail} !== 2'b10) begin errors++; $display("FAIL simul_ok_bad: got %b want 10", {success, fail}); end
    repeat (12) cyc();
    start_round();
    repeat (20 + 79) cyc();
    code_ok = 1'b1;
    cyc();
    code_ok = 1'b0;
    checks++; if ({success, fail} !== 2'b10) begin errors++; $display("FAIL simul_ok_final_tick: got %b want 10", {success, fail}); end
    repeat (12) cyc();
  endtask

  task automatic test_abort();
    logic [4:0] round_code;
    start_round();
    round_code = code;
    repeat (6) cyc();
    btn_start = 1'b1;
    cyc();
    checks++; if (show_en !== 1'b1 || sub_rst !== 1'b0) begin errors++; $display("FAIL abort_edge_in_show: got show=%b sub_rst=%b want 1/0", show_en, sub_rst); end
    sw_en = 1'b0;
    cyc();
    checks++; if ({bomb_en, show_en, input_en, success, fail} !== 5'b00000 || secs_left !== 5'd0) begin errors++; $display("FAIL abort_outputs: got %b secs=%0d want 00000 secs=0", {bomb_en, show_en, input_en, success, fail}, secs_left); end
    checks++; if (code !== 5'(m_code)) begin errors++; $display("FAIL abort_code_held: got %0d want %0d", code, m_code); end
    sw_en = 1'b1;
    code_ok = 1'b1;
    repeat (5) cyc();
    code_ok = 1'b0;
    checks++; if (show_en !== 1'b0 || success !== 1'b0) begin errors++; $display("FAIL abort_held_button: got show=%b success=%b want 0/0", show_en, success); end
    checks++; if (code !== round_code) begin errors++; $display("FAIL abort_code_stable: got %0d want %0d", code, round_code); end
    btn_start = 1'b0;
    cyc();
  endtask

  task automatic test_async_reset();
    start_round();
    repeat (29) cyc();
    #2;
    rst_p = 1'b1;
    #1;
    checks++; if (dut_vec() !== 16'h0000) begin errors++; $display("FAIL async_reset_immediate: got %h want 0000", dut_vec()); end
    model_reset();
    repeat (2) cyc();
    checks++; if (dut_vec() !== 16'h0000) begin errors++; $display("FAIL async_reset_held: got %h want 0000", dut_vec()); end
    rst_p = 1'b0;
    cyc();
    checks++; if (sub_rst !== 1'b0 || dut_vec() !== exp_vec()) begin errors++; $display("FAIL async_reset_release: got %h want %h", dut_vec(), exp_vec()); end
  endtask

`ifdef DIFFICULTY_RAMP_EN
  task automatic test_ramp();
    start_round();
    for (int w = 0; w < 3; w++) begin
      if (w > 0) launch();
      repeat (20) cyc();
      code_ok = 1'b1; cyc(); code_ok = 1'b0;
      repeat (12) cyc();
    end
    launch();
    repeat (20) cyc();
    checks++; if (secs_left !== 5'd14) begin errors++; $display("FAIL ramp_three_wins: got %0d want 14", secs_left); end
    code_bad = 1'b1; cyc(); code_bad = 1'b0;
    repeat (12) cyc();
    launch();
    repeat (20) cyc();
    checks++; if (secs_left !== 5'd20) begin errors++; $display("FAIL ramp_after_loss: got %0d want 20", secs_left); end
    for (int w = 0; w < 16; w++) begin
      if (w > 0) begin
        launch();
        repeat (20) cyc();
      end
      code_ok = 1'b1; cyc(); code_ok = 1'b0;
      repeat (12) cyc();
    end
    launch();
    repeat (20) cyc();
    checks++; if (secs_left !== 5'd4) begin errors++; $display("FAIL ramp_floor: got %0d want 4", secs_left); end
    repeat (16) cyc();
    checks++; if (fail !== 1'b1) begin errors++; $display("FAIL ramp_floor_timeout: fail got %b want 1", fail); end
    repeat (12) cyc();
  endtask
`endif

  task automatic test_random();
    int bad_cycles;
    bad_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      sw_en     = ($urandom_range(0, 99) != 0);
      btn_start = ($urandom_range(0, 7) == 0) ? ~btn_start : btn_start;
      code_ok   = ($urandom_range(0, 39) == 0);
      code_bad  = ($urandom_range(0, 39) == 0);
      cyc();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        bad_cycles++;
        if (bad_cycles <= 10) $display("FAIL random_cycle_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    code_ok = 1'b0; code_bad = 1'b0; btn_start = 1'b0; sw_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_win();
    test_timeout();
    test_simultaneous();
    test_abort();
    test_async_reset();
`ifdef DIFFICULTY_RAMP_EN
    test_ramp();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
